// File: rtl/dpi_sched_pkg.sv
// Shared definitions for the DPI stream scheduler: stream table geometry,
// FSM state encoding and the saturating counter helper.
package dpi_sched_pkg;

  localparam int NUM_STREAMS = 64;
  localparam int STREAM_ID_W = 6;
  localparam int CNT_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETUP  = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4,
    ST_COMMIT = 3'd5
  } sched_state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (v == {CNT_W{1'b1}}) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/dpi_stream_table.sv
// Per-stream context: enable-mask table and the "seen" bitmap that tells the
// matchers whether a stream has saved state to restore.
module dpi_stream_table
  import dpi_sched_pkg::*;
#(
  parameter int NUM_RX = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [NUM_RX-1:0]      cfg_mask,
  input  logic                   cfg_clr,
  input  logic [STREAM_ID_W-1:0] rd_addr,
  output logic [NUM_RX-1:0]      rd_mask,
  output logic                   rd_seen,
  input  logic                   commit,
  input  logic [STREAM_ID_W-1:0] commit_addr
);

  logic [NUM_RX-1:0]      mask_r [NUM_STREAMS];
  logic [NUM_STREAMS-1:0] seen_r;

  // Mask table: all regexes disabled after reset, rewritten by cfg_we at any time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_STREAMS; i++) begin
        mask_r[i] <= {NUM_RX{1'b0}};
      end
    end else if (cfg_we) begin
      mask_r[cfg_addr] <= cfg_mask;
    end
  end

  // Seen bitmap: the clear is written last so it overrides a same-cycle commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_r <= {NUM_STREAMS{1'b0}};
    end else begin
      if (commit) begin
        seen_r[commit_addr] <= 1'b1;
      end
      if (cfg_clr) begin
        seen_r[cfg_addr] <= 1'b0;
      end
    end
  end

  assign rd_mask = mask_r[rd_addr];
  assign rd_seen = seen_r[rd_addr];

endmodule

// File: rtl/dpi_stream_scheduler.sv
// Sequences one packet at a time into a bank of regex matchers:
// restore state, settle, stream bytes, drain pipelines, commit.
module dpi_stream_scheduler
  import dpi_sched_pkg::*;
#(
  parameter int NUM_RX       = 8,
  parameter int SETUP_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   pkt_vld,
  output logic                   pkt_rdy,
  input  logic [7:0]             pkt_data,
  input  logic                   pkt_sop,
  input  logic                   pkt_eop,
  input  logic [STREAM_ID_W-1:0] pkt_stream_id,
  input  logic                   cfg_we,
  input  logic [STREAM_ID_W-1:0] cfg_addr,
  input  logic [NUM_RX-1:0]      cfg_mask,
  input  logic                   cfg_clr,
  output logic                   load_state,
  output logic                   new_stream_id,
  output logic [STREAM_ID_W-1:0] stream_id,
  output logic [7:0]             char_in,
  output logic                   char_in_vld,
  output logic                   eop,
  output logic [NUM_RX-1:0]      enable,
  output logic                   busy,
  output logic [CNT_W-1:0]       pkt_count,
  output logic [CNT_W-1:0]       proto_err_count
);

  localparam logic [7:0] SETUP_LAST = 8'(SETUP_CYCLES - 1);
  localparam logic [7:0] DRAIN_LAST = 8'(DRAIN_CYCLES - 1);

  sched_state_e           state_r, state_next_s;
  logic [7:0]             cnt_r;
  logic                   first_r;
  logic                   load_state_r, new_stream_id_r, eop_r, busy_r;
  logic [STREAM_ID_W-1:0] stream_id_r;
  logic [NUM_RX-1:0]      enable_r;
  logic [CNT_W-1:0]       pkt_count_r, err_r;
  logic                   pkt_rdy_s, beat_s, start_s, err_inc_s;
  logic [NUM_RX-1:0]      rd_mask_s;
  logic                   rd_seen_s;

  dpi_stream_table #(.NUM_RX(NUM_RX)) u_table (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_mask    (cfg_mask),
    .cfg_clr     (cfg_clr),
    .rd_addr     (pkt_stream_id),
    .rd_mask     (rd_mask_s),
    .rd_seen     (rd_seen_s),
    .commit      (state_r == ST_COMMIT),
    .commit_addr (stream_id_r)
  );

  // Next-state and handshake decode; the sop beat in IDLE is left pending for STREAM.
  always_comb begin
    state_next_s = state_r;
    pkt_rdy_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        pkt_rdy_s = !pkt_sop;
        if (pkt_vld && pkt_sop) begin
          state_next_s = ST_LOAD;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_LOAD: begin
        if (SETUP_CYCLES == 0) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_r == SETUP_LAST) begin
          state_next_s = ST_STREAM;
        end else begin
          state_next_s = ST_SETUP;
        end
      end
      ST_STREAM: begin
        pkt_rdy_s = 1'b1;
        if (pkt_vld && pkt_eop) begin
          if (DRAIN_CYCLES == 0) begin
            state_next_s = ST_COMMIT;
          end else begin
            state_next_s = ST_DRAIN;
          end
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      ST_DRAIN: begin
        if (cnt_r == DRAIN_LAST) begin
          state_next_s = ST_COMMIT;
        end else begin
          state_next_s = ST_DRAIN;
        end
      end
      ST_COMMIT: state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  assign beat_s    = pkt_vld && pkt_rdy_s;
  assign start_s   = (state_r == ST_IDLE) && pkt_vld && pkt_sop;
  // Only the first beat of a packet may carry sop; any later sop is a framing error.
  assign err_inc_s = beat_s && ((state_r == ST_IDLE) ||
                                ((state_r == ST_STREAM) && pkt_sop && !first_r));

  // State, phase counter, latched packet context and statistics.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r         <= ST_IDLE;
      cnt_r           <= 8'd0;
      first_r         <= 1'b0;
      load_state_r    <= 1'b0;
      new_stream_id_r <= 1'b0;
      eop_r           <= 1'b0;
      busy_r          <= 1'b0;
      stream_id_r     <= {STREAM_ID_W{1'b0}};
      enable_r        <= {NUM_RX{1'b0}};
      pkt_count_r     <= 16'd0;
      err_r           <= 16'd0;
    end else begin
      state_r         <= state_next_s;
      cnt_r           <= (state_next_s != state_r) ? 8'd0 : cnt_r + 8'd1;
      load_state_r    <= start_s;
      new_stream_id_r <= start_s && !rd_seen_s;
      eop_r           <= (state_next_s == ST_COMMIT);
      busy_r          <= (state_next_s != ST_IDLE);
      if (start_s) begin
        stream_id_r <= pkt_stream_id;
        enable_r    <= rd_mask_s;
        first_r     <= 1'b1;
      end else if (beat_s && (state_r == ST_STREAM)) begin
        first_r <= 1'b0;
      end
      if (state_r == ST_COMMIT) begin
        pkt_count_r <= pkt_count_r + 16'd1;
      end
      if (err_inc_s) begin
        err_r <= sat_inc(err_r);
      end
    end
  end

  assign pkt_rdy         = rst_n && pkt_rdy_s;
  assign char_in_vld     = (state_r == ST_STREAM) && pkt_vld;
  assign char_in         = char_in_vld ? pkt_data : 8'h00;
  assign load_state      = load_state_r;
  assign new_stream_id   = new_stream_id_r;
  assign eop             = eop_r;
  assign busy            = busy_r;
  assign stream_id       = stream_id_r;
  assign enable          = enable_r;
  assign pkt_count       = pkt_count_r;
  assign proto_err_count = err_r;

endmodule
